// File: rtl/vpu_op_sequencer.sv
// Issue stage for the VPU delay counter: buffers decoded ops, launches the counter with each
// op's table latency, waits for done, then offers an in-order writeback token downstream.
module vpu_op_sequencer #(
  parameter int unsigned OPCODE_W      = 4,
  parameter int unsigned MAX_DELAY_LG2 = 4,
  parameter int unsigned DST_W         = 5,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [(2**OPCODE_W)*MAX_DELAY_LG2-1:0] LAT_TABLE = 64'hFEDC_BA98_7654_3210
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [OPCODE_W-1:0]      req_opcode_i,
  input  logic [DST_W-1:0]         req_dst_i,
  output logic                     cntr_start_o,
  output logic [MAX_DELAY_LG2-1:0] cntr_count_o,
  input  logic                     cntr_done_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DST_W-1:0]         wb_dst_o,
  output logic [OPCODE_W-1:0]      wb_opcode_o,
  output logic                     illegal_o,
  output logic                     busy_o
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NUM_OPS = 2**OPCODE_W;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DST_W-1:0]    dst;
  } req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_WB} state_e;

  req_t                     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           fill_q, fill_d;
  logic [MAX_DELAY_LG2-1:0] lat_rom [NUM_OPS];

  state_e                   state_q;
  logic [OPCODE_W-1:0]      opcode_q;
  logic [DST_W-1:0]         dst_q;
  logic [MAX_DELAY_LG2-1:0] count_q;

  logic                     push, pop, fifo_full, fifo_empty;
  req_t                     head;
  logic [MAX_DELAY_LG2-1:0] head_lat;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lat
    assign lat_rom[g] = LAT_TABLE[g*MAX_DELAY_LG2 +: MAX_DELAY_LG2];
  end

  assign fifo_full  = (fill_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign push       = req_valid_i && !fifo_full;
  // Only the idle FSM consumes the head, so ready never depends on FSM decisions this cycle.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q];
  assign head_lat   = lat_rom[head.opcode];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: FIFO storage has no reset; the fill count guarantees stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{opcode: req_opcode_i, dst: req_dst_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      dst_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop && head_lat != '0) begin
            opcode_q <= head.opcode;
            dst_q    <= head.dst;
            count_q  <= head_lat;
            state_q  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state_q <= ST_WAIT;
        ST_WAIT:   if (cntr_done_i) state_q <= ST_WB;
        ST_WB:     if (wb_ready_i)  state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = !fifo_full;
  assign illegal_o    = pop && (head_lat == '0);
  assign cntr_start_o = (state_q == ST_LAUNCH);
  assign cntr_count_o = count_q;
  assign wb_valid_o   = (state_q == ST_WB);
  assign wb_dst_o     = wb_valid_o ? dst_q    : '0;
  assign wb_opcode_o  = wb_valid_o ? opcode_q : '0;
  assign busy_o       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vpu_op_sequencer.sv
// Bench for vpu_op_sequencer: directed scenarios plus a random phase, all scored against a
// transaction-level model (op queue, in-flight op, counter emulation) kept in the bench.
module tb_vpu_op_sequencer;

  typedef struct {
    logic [3:0] op;
    logic [4:0] dst;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_i, req_ready_o;
  logic [3:0] req_opcode_i;
  logic [4:0] req_dst_i;
  logic       cntr_start_o;
  logic [3:0] cntr_count_o;
  logic       cntr_done_i;
  logic       wb_valid_o, wb_ready_i;
  logic [4:0] wb_dst_o;
  logic [3:0] wb_opcode_o;
  logic       illegal_o, busy_o;

  vpu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_dst_i(req_dst_i),
    .cntr_start_o(cntr_start_o), .cntr_count_o(cntr_count_o), .cntr_done_i(cntr_done_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_dst_o(wb_dst_o), .wb_opcode_o(wb_opcode_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  int  cyc = 0, acc_cyc = 0, start_cyc = 0;
  int  n_illegal = 0, n_start = 0, n_tok = 0;
  int  timer = 0;
  bit  auto_done = 1'b1, spur_en = 1'b0;
  op_t model_q[$];
  op_t inflight;
  bit  inflight_v = 1'b0, wb_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scores the current cycle (inputs applied, outputs settled), then advances one clock.
  task automatic tick();
    op_t h;
    bit  real_done, hs;
    check("busy", busy_o, (model_q.size() != 0) || inflight_v);
    if (cntr_start_o) begin
      n_start++;
      start_cyc = cyc;
      check("start_while_inflight", inflight_v, 1'b0);
      check("start_has_op", model_q.size() != 0, 1'b1);
      if (model_q.size() != 0) begin
        h = model_q.pop_front();
        check("start_op_legal", h.op != 4'd0, 1'b1);
        check("start_count", cntr_count_o, h.op);
        inflight   = h;
        inflight_v = 1'b1;
      end
    end else if (inflight_v && !wb_pend) begin
      check("count_hold", cntr_count_o, inflight.op);
    end
    check("wb_valid", wb_valid_o, wb_pend);
    if (wb_valid_o) begin
      check("wb_dst", wb_dst_o, inflight.dst);
      check("wb_opcode", wb_opcode_o, inflight.op);
    end else begin
      check("wb_dst_idle", wb_dst_o, 5'd0);
      check("wb_opcode_idle", wb_opcode_o, 4'd0);
    end
    if (illegal_o) begin
      n_illegal++;
      check("illegal_has_op", model_q.size() != 0, 1'b1);
      if (model_q.size() != 0) begin
        h = model_q.pop_front();
        check("illegal_op_zero", h.op, 4'd0);
      end
    end
    real_done = cntr_done_i && inflight_v && !cntr_start_o && !wb_pend;
    hs        = wb_valid_o && wb_ready_i;
    if (req_valid_i && req_ready_o) begin
      model_q.push_back('{op: req_opcode_i, dst: req_dst_i});
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (real_done) wb_pend = 1'b1;
    if (hs) begin
      n_tok++;
      wb_pend    = 1'b0;
      inflight_v = 1'b0;
    end
    if (auto_done) begin
      cntr_done_i = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) cntr_done_i = 1'b1;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        cntr_done_i = 1'b1;
      end
      if (cntr_start_o) timer = int'(cntr_count_o);
    end
  endtask

  task automatic push_op(input logic [3:0] op, input logic [4:0] dst);
    int k = 0;
    req_valid_i  = 1'b1;
    req_opcode_i = op;
    req_dst_i    = dst;
    while (!req_ready_o && k < 100) begin
      tick();
      k++;
    end
    check("push_ready_timeout", k < 100, 1'b1);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    req_valid_i = 1'b0;
    wb_ready_i  = 1'b1;
    while ((busy_o || model_q.size() != 0 || inflight_v) && k < 400) begin
      tick();
      k++;
    end
    check("drain_timeout", k < 400, 1'b1);
  endtask

  initial begin
    op_t ops2[7];
    int  acc, t0, i0, s0, k;

    rst_n = 1'b0; req_valid_i = 1'b0; req_opcode_i = '0; req_dst_i = '0;
    cntr_done_i = 1'b0; wb_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_start", cntr_start_o, 1'b0);
    check("rst_count", cntr_count_o, 4'd0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_illegal", illegal_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: single op, start two cycles after accept, one-cycle token.
    wb_ready_i = 1'b1;
    t0 = n_tok;
    push_op(4'd3, 5'd5);
    drain();
    check("t1_start_latency", start_cyc - acc_cyc, 2);
    check("t1_tokens", n_tok - t0, 1);

    // 2: back-pressure fills the FIFO after five accepts.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) ops2[i] = '{op: 4'(i + 1), dst: 5'(10 + i)};
    acc = 0;
    t0  = n_tok;
    for (int i = 0; i < 7; i++) begin
      req_valid_i  = 1'b1;
      req_opcode_i = ops2[acc].op;
      req_dst_i    = ops2[acc].dst;
      if (i == 5) check("t2_full_after5", req_ready_o, 1'b0);
      if (req_ready_o) acc++;
      tick();
    end
    check("t2_accepted", acc, 5);
    check("t2_still_full", req_ready_o, 1'b0);
    drain();
    check("t2_tokens", n_tok - t0, 5);
    check("t2_ready_back", req_ready_o, 1'b1);

    // 3: illegal opcode between two legal ops.
    i0 = n_illegal; s0 = n_start; t0 = n_tok;
    wb_ready_i = 1'b1;
    push_op(4'd2, 5'd1);
    push_op(4'd0, 5'd2);
    push_op(4'd4, 5'd3);
    drain();
    check("t3_illegal", n_illegal - i0, 1);
    check("t3_starts", n_start - s0, 2);
    check("t3_tokens", n_tok - t0, 2);

    // 4: token held for seven cycles while the next op waits.
    wb_ready_i = 1'b0;
    push_op(4'd2, 5'd9);
    push_op(4'd1, 5'd3);
    k = 0;
    while (!wb_valid_o && k < 100) begin tick(); k++; end
    check("t4_wb_timeout", k < 100, 1'b1);
    s0 = n_start;
    for (int i = 0; i < 7; i++) begin
      check("t4_wb_hold_valid", wb_valid_o, 1'b1);
      check("t4_wb_hold_dst", wb_dst_o, 5'd9);
      check("t4_wb_hold_op", wb_opcode_o, 4'd2);
      tick();
    end
    check("t4_no_start", n_start - s0, 0);
    drain();

    // 5: reset in the middle of WAIT.
    wb_ready_i = 1'b1;
    push_op(4'd8, 5'd4);
    k = 0;
    while (!cntr_start_o && k < 20) begin tick(); k++; end
    check("t5_start_timeout", k < 20, 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ready", req_ready_o, 1'b1);
    check("t5_rst_count", cntr_count_o, 4'd0);
    check("t5_rst_start", cntr_start_o, 1'b0);
    check("t5_rst_wb", wb_valid_o, 1'b0);
    check("t5_rst_busy", busy_o, 1'b0);
    model_q.delete();
    inflight_v = 1'b0; wb_pend = 1'b0; timer = 0; auto_done = 1'b0; cntr_done_i = 1'b0;
    tick();
    rst_n = 1'b1;
    t0 = n_tok; s0 = n_start;
    cntr_done_i = 1'b1;
    tick();
    cntr_done_i = 1'b0;
    repeat (3) tick();
    check("t5_busy_after", busy_o, 1'b0);
    check("t5_no_token", n_tok - t0, 0);
    check("t5_no_start", n_start - s0, 0);

    // 6: done in IDLE and LAUNCH ignored; only done in WAIT completes.
    cntr_done_i = 1'b1;
    tick();
    req_valid_i = 1'b1; req_opcode_i = 4'd3; req_dst_i = 5'd7;
    tick();
    req_valid_i = 1'b0;
    tick();
    check("t6_launch", cntr_start_o, 1'b1);
    tick();
    cntr_done_i = 1'b0;
    repeat (3) tick();
    check("t6_no_early_wb", wb_valid_o, 1'b0);
    cntr_done_i = 1'b1;
    tick();
    cntr_done_i = 1'b0;
    check("t6_wb_valid", wb_valid_o, 1'b1);
    check("t6_wb_dst", wb_dst_o, 5'd7);
    drain();

    // Random traffic with random back-pressure and spurious done pulses.
    auto_done = 1'b1;
    spur_en   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      req_valid_i  = 1'($urandom_range(0, 1));
      req_opcode_i = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      req_dst_i    = 5'($urandom);
      wb_ready_i   = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("final_busy", busy_o, 1'b0);
    check("final_ready", req_ready_o, 1'b1);
    check("final_model_empty", model_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
